mult_div_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the pipelined MIPS core. Implements MULT, MULTU, DIV and DIVU, and owns the architectural HI and LO registers.
- Sits beside the ALU in the EX stage. The hazard logic stalls IF/ID/EX while Busy is high.
- MFHI/MFLO read HI/LO directly. MTHI/MTLO write them through the WriteHI/WriteLO port.
- Radix-2 algorithm: one bit per cycle, shift-add for multiply, restoring division for divide.

---
 rtl/mult_div_unit.sv | 134 +++++++++++++
 tb/tb_mult_div_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit that owns the architectural HI/LO registers.
// Shift-add multiply and restoring divide run on operand magnitudes; signs are restored in FIX.
module mult_div_unit #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WriteHI,
  input  logic             WriteLO,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} stateType;

  stateType            state, nextState;
  logic [CNT_BITS-1:0] count;
  logic [1:0]          opReg;
  logic                signA, signB, zeroB;
  logic [WIDTH-1:0]    operB, workHi, workLo;

  logic [WIDTH-1:0]    absA, absB;
  logic [WIDTH:0]      mulSum, divShift;
  logic                divFits, lastIter;
  logic [2*WIDTH-1:0]  product;
  logic [WIDTH-1:0]    resHi, resLo;

  assign absA     = (Op[0] && A[WIDTH-1]) ? -A : A;
  assign absB     = (Op[0] && B[WIDTH-1]) ? -B : B;
  assign mulSum   = {1'b0, workHi} + (workLo[0] ? {1'b0, operB} : '0);
  assign divShift = {workHi, workLo[WIDTH-1]};
  assign divFits  = (divShift >= {1'b0, operB});
  assign lastIter = (count == CNT_BITS'(WIDTH - 1));
  assign Busy     = (state != IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    // NOTE: default first so no path leaves nextState unassigned (no latch).
    nextState = state;
    case (state)
      IDLE:    if (Start) nextState = RUN;
      RUN:     if (lastIter) nextState = FIX;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Sign correction: product negated as a whole; quotient by sign mismatch, remainder by dividend.
  always_comb begin
    product = {workHi, workLo};
    resHi   = workHi;
    resLo   = workLo;
    if (opReg[1]) begin
      if (zeroB)                              resLo = '1;
      else if (opReg[0] && (signA ^ signB))   resLo = -workLo;
      if (opReg[0] && signA)                  resHi = -workHi;
    end else begin
      if (opReg[0] && (signA ^ signB)) product = -{workHi, workLo};
      resHi = product[2*WIDTH-1:WIDTH];
      resLo = product[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      opReg  <= '0;
      signA  <= 1'b0;
      signB  <= 1'b0;
      zeroB  <= 1'b0;
      operB  <= '0;
      workHi <= '0;
      workLo <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          opReg  <= Op;
          signA  <= Op[0] & A[WIDTH-1];
          signB  <= Op[0] & B[WIDTH-1];
          zeroB  <= (B == '0);
          count  <= '0;
          workHi <= '0;
          // Divide shifts the dividend out of workLo; multiply shifts the multiplier out.
          workLo <= Op[1] ? absA : absB;
          operB  <= Op[1] ? absB : absA;
        end
        RUN: begin
          count <= count + 1'b1;
          if (opReg[1]) begin
            workHi <= divFits ? (divShift[WIDTH-1:0] - operB) : divShift[WIDTH-1:0];
            workLo <= {workLo[WIDTH-2:0], divFits};
          end else begin
            {workHi, workLo} <= {mulSum, workLo[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI        <= '0;
      LO        <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= (state == FIX);
      if (state == FIX) begin
        HI        <= resHi;
        LO        <= resLo;
        DivByZero <= opReg[1] & zeroB;
      end else if (state == IDLE) begin
        if (WriteHI) HI <= WriteData;
        if (WriteLO) LO <= WriteData;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: 32-bit and 8-bit instances checked against an
// arithmetic reference model; a monitor per instance pops expectations on Done.
module tb_mult_div_unit;

  localparam int W  = 32;
  localparam int W8 = 8;
  localparam logic [1:0] MULTU = 2'd0, MULT = 2'd1, DIVU = 2'd2, DIV = 2'd3;

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    logic        dbz;
  } expT;

  logic clk = 1'b0;
  logic reset;

  logic          start, wrHi, wrLo, busy, done, dbz;
  logic [1:0]    op;
  logic [W-1:0]  a, b, wrData, hi, lo;
  logic          start8, wrHi8, wrLo8, busy8, done8, dbz8;
  logic [1:0]    op8;
  logic [W8-1:0] a8, b8, wrData8, hi8, lo8;

  expT         q32[$], q8[$];
  expT         e32, e8;
  int          checks = 0, errors = 0;
  longint      cycle = 0, start32 = 0, start8c = 0;
  int          busy32 = 0, busyCnt8 = 0;
  logic [63:0] archHi = '0, archLo = '0, arch8Hi = '0, arch8Lo = '0;
  logic        archDbz = 1'b0, arch8Dbz = 1'b0;

  mult_div_unit #(.WIDTH(W), .CNT_BITS(6)) dut (
    .clk(clk), .reset(reset), .Start(start), .Op(op), .A(a), .B(b),
    .WriteHI(wrHi), .WriteLO(wrLo), .WriteData(wrData),
    .Busy(busy), .Done(done), .DivByZero(dbz), .HI(hi), .LO(lo)
  );

  mult_div_unit #(.WIDTH(W8), .CNT_BITS(4)) dut8 (
    .clk(clk), .reset(reset), .Start(start8), .Op(op8), .A(a8), .B(b8),
    .WriteHI(wrHi8), .WriteLO(wrLo8), .WriteData(wrData8),
    .Busy(busy8), .Done(done8), .DivByZero(dbz8), .HI(hi8), .LO(lo8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands interpreted per Op.
  function automatic expT refModel(input int w, input logic [1:0] o, input logic [63:0] x,
                                   input logic [63:0] y);
    logic signed [127:0] sx, sy, p, q, r;
    logic [127:0] mask;
    expT e;
    mask = (128'd1 << w) - 128'd1;
    sx = $signed({64'd0, x});
    sy = $signed({64'd0, y});
    if (o[0] && x[w-1]) sx = sx - $signed(128'd1 << w);
    if (o[0] && y[w-1]) sy = sy - $signed(128'd1 << w);
    e.dbz = 1'b0;
    if (!o[1]) begin
      p    = sx * sy;
      e.lo = 64'(p & mask);
      e.hi = 64'((p >> w) & mask);
    end else if (y == 64'd0) begin
      e.lo  = 64'(mask);
      e.hi  = x;
      e.dbz = 1'b1;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      e.lo = 64'(q & mask);
      e.hi = 64'(r & mask);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (busy) busy32++;
      if (done) begin
        checks++;
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL done32 spurious Done=1 with no operation pending");
        end else begin
          e32 = q32.pop_front();
          check("HI32", 64'(hi), e32.hi);
          check("LO32", 64'(lo), e32.lo);
          check("DBZ32", 64'(dbz), 64'(e32.dbz));
          check("busyCycles32", 64'(busy32), 64'(W + 1));
          archHi = e32.hi; archLo = e32.lo; archDbz = e32.dbz;
        end
        busy32 = 0;
      end else begin
        check("holdHI32", 64'(hi), archHi);
        check("holdLO32", 64'(lo), archLo);
        check("holdDBZ32", 64'(dbz), 64'(archDbz));
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (busy8) busyCnt8++;
      if (done8) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL done8 spurious Done=1 with no operation pending");
        end else begin
          e8 = q8.pop_front();
          check("HI8", 64'(hi8), e8.hi);
          check("LO8", 64'(lo8), e8.lo);
          check("DBZ8", 64'(dbz8), 64'(e8.dbz));
          check("busyCycles8", 64'(busyCnt8), 64'(W8 + 1));
          arch8Hi = e8.hi; arch8Lo = e8.lo; arch8Dbz = e8.dbz;
        end
        busyCnt8 = 0;
      end else begin
        check("holdHI8", 64'(hi8), arch8Hi);
        check("holdLO8", 64'(lo8), arch8Lo);
      end
    end
  end

  task automatic startOp32(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic wh = 1'b0, input logic wl = 1'b0,
                           input logic [W-1:0] wd = '0);
    start = 1'b1; op = o; a = x; b = y; wrHi = wh; wrLo = wl; wrData = wd;
    @(posedge clk);
    q32.push_back(refModel(W, o, 64'(x), 64'(y)));
    if (wh) archHi = 64'(wd);
    if (wl) archLo = 64'(wd);
    #1 start = 1'b0; wrHi = 1'b0; wrLo = 1'b0;
    start32 = cycle;
  endtask

  task automatic waitDone32();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 200);
    check("latency32", 64'(cycle - start32), 64'(W + 1));
  endtask

  task automatic write32(input logic wh, input logic wl, input logic [W-1:0] wd);
    wrHi = wh; wrLo = wl; wrData = wd;
    @(posedge clk);
    if (wh) archHi = 64'(wd);
    if (wl) archLo = 64'(wd);
    #1 wrHi = 1'b0; wrLo = 1'b0;
  endtask

  task automatic startOp8(input logic [1:0] o, input logic [W8-1:0] x, input logic [W8-1:0] y);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk);
    q8.push_back(refModel(W8, o, 64'(x), 64'(y)));
    #1 start8 = 1'b0;
    start8c = cycle;
  endtask

  task automatic waitDone8();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done8 && n < 100);
    check("latency8", 64'(cycle - start8c), 64'(W8 + 1));
  endtask

  function automatic logic [W-1:0] pick32();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic directed32(input string name, input logic [1:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] expHi,
                            input logic [W-1:0] expLo, input logic expDbz);
    startOp32(o, x, y);
    waitDone32();
    check({name, ".HI"}, 64'(hi), 64'(expHi));
    check({name, ".LO"}, 64'(lo), 64'(expLo));
    check({name, ".DBZ"}, 64'(dbz), 64'(expDbz));
    check({name, ".donePulse"}, 64'(done), 64'd1);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b0;
    start = 1'b0; op = '0; a = '0; b = '0; wrHi = 1'b0; wrLo = 1'b0; wrData = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; wrHi8 = 1'b0; wrLo8 = 1'b0; wrData8 = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("rst.HI", 64'(hi), 64'd0);
    check("rst.LO", 64'(lo), 64'd0);
    check("rst.Busy", 64'(busy), 64'd0);
    check("rst.Done", 64'(done), 64'd0);
    check("rst.DBZ", 64'(dbz), 64'd0);

    directed32("multuMax", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(negedge clk);
    directed32("multMinus1", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
    directed32("divNeg7by2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    directed32("divMinByM1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    directed32("divuByZero", DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
    directed32("multu3x5", MULTU, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0);
    directed32("divNegByZero", DIV, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);

    // Start and a write during RUN are both ignored; the next Start lands in the Done cycle.
    @(negedge clk);
    startOp32(MULTU, 32'h1000, 32'h10);
    repeat (4) @(negedge clk);
    start = 1'b1; op = DIV; a = 32'd5; b = 32'd0; wrHi = 1'b1; wrData = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    start = 1'b0; wrHi = 1'b0;
    waitDone32();
    startOp32(DIVU, 32'd100, 32'd7);
    waitDone32();

    @(negedge clk);
    write32(1'b1, 1'b0, 32'h1111_2222);
    write32(1'b0, 1'b1, 32'h3333_4444);
    write32(1'b1, 1'b1, 32'h5555_6666);
    startOp32(MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1, 32'h7777_8888);
    waitDone32();

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [W-1:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = pick32();
      y = ($urandom_range(0, 7) == 0) ? '0 : pick32();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      if ($urandom_range(0, 3) == 0) write32(1'($urandom), 1'($urandom), $urandom);
      startOp32(o, x, y, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0), $urandom);
      waitDone32();
    end

    // Asynchronous reset mid-RUN aborts with no partial result.
    @(negedge clk);
    write32(1'b1, 1'b1, 32'hA5A5_A5A5);
    startOp32(MULTU, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midRst.Busy", 64'(busy), 64'd0);
    check("midRst.HI", 64'(hi), 64'd0);
    check("midRst.LO", 64'(lo), 64'd0);
    check("midRst.Done", 64'(done), 64'd0);
    q32.delete();
    archHi = '0; archLo = '0; archDbz = 1'b0; busy32 = 0;
    arch8Hi = '0; arch8Lo = '0; arch8Dbz = 1'b0; busyCnt8 = 0;
    repeat (3) begin
      @(negedge clk);
      check("inRst.Done", 64'(done), 64'd0);
    end
    #2 reset = 1'b1;
    @(negedge clk);
    directed32("afterRst", MULTU, 32'd7, 32'd9, 32'h0, 32'd63, 1'b0);

    // 8-bit instance.
    @(negedge clk);
    startOp8(MULT, 8'h80, 8'h80);
    waitDone8();
    check("w8.multHI", 64'(hi8), 64'h40);
    check("w8.multLO", 64'(lo8), 64'h00);
    @(negedge clk);
    wrLo8 = 1'b1; wrData8 = 8'h5A;
    @(posedge clk);
    arch8Lo = 64'h5A;
    #1 wrLo8 = 1'b0;
    @(negedge clk);
    check("w8.writeLO", 64'(lo8), 64'h5A);
    startOp8(MULTU, 8'd3, 8'd4);
    @(negedge clk);
    wrHi8 = 1'b1; wrData8 = 8'hEE;
    @(negedge clk);
    wrHi8 = 1'b0;
    check("w8.busyWriteHI", 64'(hi8), 64'h40);
    waitDone8();
    check("w8.multuLO", 64'(lo8), 64'd12);
    for (int i = 0; i < 30; i++) begin
      startOp8(2'($urandom_range(0, 3)), 8'($urandom),
               ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
      waitDone8();
    end

    repeat (3) @(negedge clk);
    check("q32.drained", 64'(q32.size()), 64'd0);
    check("q8.drained", 64'(q8.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
